// File: rtl/acc_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_cpu_pkg
// Description : Shared definitions for the accumulator CPU core: opcode
//               encodings, opcode field width and control FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_cpu_pkg;

    // Width of the opcode field held in the top bits of every instruction
    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_LOAD  = 3'd0;
    localparam logic [OPC_W-1:0] OP_STORE = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD   = 3'd2;
    localparam logic [OPC_W-1:0] OP_SUB   = 3'd3;
    localparam logic [OPC_W-1:0] OP_AND   = 3'd4;
    localparam logic [OPC_W-1:0] OP_JMP   = 3'd5;
    localparam logic [OPC_W-1:0] OP_JZ    = 3'd6;
    localparam logic [OPC_W-1:0] OP_HALT  = 3'd7;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/acc_cpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : acc_cpu_alu
// Description : Combinational accumulator datapath. Combines AC with the
//               memory operand according to the opcode and flags signed
//               two's-complement overflow for ADD and SUB.
// Ports       : i_op      - opcode of the executing instruction
//               i_acc     - current accumulator value
//               i_operand - data returned by memory
//               o_result  - new accumulator value (AC for non-ALU opcodes)
//               o_ovf_evt - signed overflow occurred in this ADD/SUB
// Revision    : 1.0 - initial release
// ============================================================================
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 18
) (
    input  logic [OPC_W-1:0]  i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf_evt
);

    always_comb begin
        o_result  = i_acc;
        o_ovf_evt = 1'b0;
        case (i_op)
            OP_LOAD: o_result = i_operand;
            OP_ADD: begin
                o_result  = i_acc + i_operand;
                o_ovf_evt = (i_acc[DATA_W-1] == i_operand[DATA_W-1]) &&
                            (o_result[DATA_W-1] != i_acc[DATA_W-1]);
            end
            OP_SUB: begin
                // Subtraction adds the inverted operand, so overflow is judged
                // against the operand's complemented sign.
                o_result  = i_acc - i_operand;
                o_ovf_evt = (i_acc[DATA_W-1] == ~i_operand[DATA_W-1]) &&
                            (o_result[DATA_W-1] != i_acc[DATA_W-1]);
            end
            OP_AND:  o_result = i_acc & i_operand;
            default: o_result = i_acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : acc_cpu_core
// Description : Multi-cycle accumulator processor (PC, IR, AC, control FSM)
//               talking to a single-port memory over a req/ack handshake that
//               tolerates any number of wait states.
// Ports       : clk, reset          - clock and synchronous active-high reset
//               mem_req/we/addr/wdata - registered request, held until ack
//               mem_rdata, mem_ack  - read data and one-cycle completion
//               leds                - low bits of the last stored AC
//               halted, ovf, dbg_pc - status and current program counter
// Revision    : 1.0 - initial release
// ============================================================================
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int          DATA_W   = 18,
    parameter int          ADDR_W   = 13,
    parameter int          LED_W    = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [LED_W-1:0]  leds,
    output logic              halted,
    output logic              ovf,
    output logic [ADDR_W-1:0] dbg_pc
);

    localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

    state_t              r_state_q, w_state_d;
    logic [ADDR_W-1:0]   r_pc_q,    w_pc_d;
    logic [DATA_W-1:0]   r_ir_q,    w_ir_d;
    logic [DATA_W-1:0]   r_ac_q,    w_ac_d;
    logic [LED_W-1:0]    r_leds_q,  w_leds_d;
    logic                r_ovf_q,   w_ovf_d;
    logic                r_req_q,   w_req_d;
    logic                r_we_q,    w_we_d;
    logic [ADDR_W-1:0]   r_addr_q,  w_addr_d;
    logic [DATA_W-1:0]   r_wdata_q, w_wdata_d;

    logic [OPC_W-1:0]    w_opcode;
    logic [ADDR_W-1:0]   w_operand;
    logic [ADDR_W-1:0]   w_branch_pc;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_ovf;
    logic                w_ir_unused;

    assign w_opcode  = r_ir_q[DATA_W-1 -: OPC_W];
    assign w_operand = r_ir_q[ADDR_W-1:0];
    // Bits between the opcode and operand fields carry no meaning
    assign w_ir_unused = &{1'b0, r_ir_q};
    // An ack only counts while a request is actually outstanding
    assign w_xfer    = r_req_q & mem_ack;

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op      (w_opcode),
        .i_acc     (r_ac_q),
        .i_operand (mem_rdata),
        .o_result  (w_alu_result),
        .o_ovf_evt (w_alu_ovf)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_pc_d      = r_pc_q;
        w_ir_d      = r_ir_q;
        w_ac_d      = r_ac_q;
        w_leds_d    = r_leds_q;
        w_ovf_d     = r_ovf_q;
        w_req_d     = r_req_q;
        w_we_d      = r_we_q;
        w_addr_d    = r_addr_q;
        w_wdata_d   = r_wdata_q;
        w_branch_pc = r_pc_q;

        case (r_state_q)
            S_FETCH: begin
                if (!r_req_q) begin
                    // Only reached straight after reset; every other entry to
                    // FETCH arrives with its read already issued.
                    w_req_d  = 1'b1;
                    w_we_d   = 1'b0;
                    w_addr_d = r_pc_q;
                end else if (mem_ack) begin
                    w_ir_d    = mem_rdata;
                    w_pc_d    = r_pc_q + ADDR_W'(1);
                    w_req_d   = 1'b0;
                    w_state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (w_opcode)
                    OP_JMP, OP_JZ: begin
                        if (w_opcode == OP_JMP || r_ac_q == '0) begin
                            w_branch_pc = w_operand;
                        end
                        // Issue the next fetch directly so a branch costs
                        // only two cycles.
                        w_pc_d    = w_branch_pc;
                        w_req_d   = 1'b1;
                        w_we_d    = 1'b0;
                        w_addr_d  = w_branch_pc;
                        w_state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        w_state_d = S_HALT;
                    end
                    default: begin
                        w_req_d   = 1'b1;
                        w_we_d    = (w_opcode == OP_STORE);
                        w_addr_d  = w_operand;
                        w_wdata_d = r_ac_q;
                        w_state_d = S_EXEC;
                    end
                endcase
            end

            S_EXEC: begin
                if (w_xfer) begin
                    if (w_opcode == OP_STORE) begin
                        w_leds_d = r_ac_q[LED_W-1:0];
                    end else begin
                        w_ac_d  = w_alu_result;
                        w_ovf_d = r_ovf_q | w_alu_ovf;
                    end
                    // Back-to-back fetch keeps mem_req high across the edge
                    w_req_d   = 1'b1;
                    w_we_d    = 1'b0;
                    w_addr_d  = r_pc_q;
                    w_state_d = S_FETCH;
                end
            end

            S_HALT: begin
                w_req_d = 1'b0;
            end

            default: begin
                w_state_d = S_FETCH;
                w_req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_FETCH;
            r_pc_q    <= C_RESET_PC;
            r_ir_q    <= '0;
            r_ac_q    <= '0;
            r_leds_q  <= '0;
            r_ovf_q   <= 1'b0;
            r_req_q   <= 1'b0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_ir_q    <= w_ir_d;
            r_ac_q    <= w_ac_d;
            r_leds_q  <= w_leds_d;
            r_ovf_q   <= w_ovf_d;
            r_req_q   <= w_req_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
        end
    end

    assign mem_req   = r_req_q;
    assign mem_we    = r_we_q;
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign leds      = r_leds_q;
    assign halted    = (r_state_q == S_HALT);
    assign ovf       = r_ovf_q;
    assign dbg_pc    = r_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_cpu_core
// Description : Self-checking bench for acc_cpu_core. An instruction-level
//               interpreter predicts every memory transaction and the final
//               architectural state; a memory/monitor process with
//               configurable wait states compares completed transactions
//               against that expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_cpu_core;

    localparam int DW    = 18;
    localparam int AW    = 13;
    localparam int LW    = 10;
    localparam int MSIZE = 1 << AW;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr, dbg_pc;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [LW-1:0] leds;
    logic          halted, ovf;

    // Small-parameter instance with its own zero-wait memory
    logic          m2_req, m2_we, m2_ack, halted2, ovf2;
    logic [7:0]    m2_addr, dbg_pc2;
    logic [11:0]   m2_wdata, m2_rdata;
    logic [3:0]    leds2;
    logic [11:0]   mem2 [0:255];

    logic [DW-1:0] mem     [0:MSIZE-1];
    logic [DW-1:0] ref_mem [0:MSIZE-1];
    txn_t          exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int waits    = 0;
    int wcnt     = 0;
    bit inject_ack = 1'b0;

    // Model results of the current program
    logic [DW-1:0] exp_ac;
    logic [LW-1:0] exp_leds;
    bit            exp_ovf;
    int            exp_pc;

    // Memory-side history of the previous cycle
    bit            p_req = 1'b0, p_we = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;

    always #5 clk = ~clk;

    acc_cpu_core #(
        .DATA_W(DW), .ADDR_W(AW), .LED_W(LW), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .leds(leds), .halted(halted), .ovf(ovf), .dbg_pc(dbg_pc)
    );

    acc_cpu_core #(
        .DATA_W(12), .ADDR_W(8), .LED_W(4), .RESET_PC(0)
    ) dut2 (
        .clk(clk), .reset(reset),
        .mem_req(m2_req), .mem_we(m2_we), .mem_addr(m2_addr),
        .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .mem_ack(m2_ack),
        .leds(leds2), .halted(halted2), .ovf(ovf2), .dbg_pc(dbg_pc2)
    );

    assign m2_ack   = m2_req;
    assign m2_rdata = mem2[m2_addr];
    always @(posedge clk) begin
        if (m2_req && m2_we && !reset) mem2[m2_addr] <= m2_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ins(input int op, input int opnd, input int junk);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 3]  = op[2:0];
        w[AW-1:0]     = opnd[AW-1:0];
        w[DW-4:AW]    = junk[1:0];
        return w;
    endfunction

    function automatic int to_signed(input logic [DW-1:0] v);
        return v[DW-1] ? int'(v) - (1 << DW) : int'(v);
    endfunction

    // Instruction-level interpreter: walks the program, queuing every memory
    // transaction in order and recording the final architectural state.
    task automatic run_model();
        int            pc = 0;
        logic [DW-1:0] ac = '0;
        logic [DW-1:0] ir, d;
        int            op, opnd, r;
        exp_ovf  = 1'b0;
        exp_leds = '0;
        for (int step = 0; step < 2000; step++) begin
            exp_q.push_back('{we: 1'b0, addr: AW'(pc), wdata: '0});
            ir   = ref_mem[pc];
            pc   = (pc + 1) % MSIZE;
            op   = int'(ir[DW-1 -: 3]);
            opnd = int'(ir[AW-1:0]);
            if (op == 7) break;
            if (op == 5) begin pc = opnd; continue; end
            if (op == 6) begin if (ac == 0) pc = opnd; continue; end
            if (op == 1) begin
                exp_q.push_back('{we: 1'b1, addr: AW'(opnd), wdata: ac});
                ref_mem[opnd] = ac;
                exp_leds = ac[LW-1:0];
                continue;
            end
            exp_q.push_back('{we: 1'b0, addr: AW'(opnd), wdata: '0});
            d = ref_mem[opnd];
            if (op == 0) ac = d;
            else if (op == 4) ac = ac & d;
            else begin
                r = (op == 2) ? to_signed(ac) + to_signed(d) : to_signed(ac) - to_signed(d);
                if (r > (1 << (DW-1)) - 1 || r < -(1 << (DW-1))) exp_ovf = 1'b1;
                ac = r[DW-1:0];
            end
        end
        exp_ac = ac;
        exp_pc = pc;
    endtask

    // Memory model and monitor. Each negedge first settles the edge just
    // passed (completion or hold check), then decides this cycle's ack.
    always @(negedge clk) begin
        txn_t e;
        if (p_req && !p_rst) begin
            if (p_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL txn_unexpected: got we=%0b addr=%0h, expected no transaction", p_we, p_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_we", 32'(p_we), 32'(e.we));
                    check("txn_addr", 32'(p_addr), 32'(e.addr));
                    if (e.we) check("txn_wdata", 32'(p_wdata), 32'(e.wdata));
                end
                if (p_we) mem[p_addr] = p_wdata;
                wcnt = 0;
            end else begin
                check("hold_req", 32'(mem_req), 32'd1);
                check("hold_addr", 32'(mem_addr), 32'(p_addr));
                check("hold_we", 32'(mem_we), 32'(p_we));
                check("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
            end
        end
        if (p_rst) wcnt = 0;
        p_req   = mem_req;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_rst   = reset;
        if (mem_req && !reset && wcnt >= waits) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
        end else begin
            mem_ack   = inject_ack;
            mem_rdata = DW'($urandom);
            if (mem_req) wcnt++;
        end
        p_ack = mem_ack;
    end

    task automatic clear_mem();
        for (int i = 0; i < MSIZE; i++) mem[i] = '0;
    endtask

    task automatic start_prog(input int w);
        for (int i = 0; i < MSIZE; i++) ref_mem[i] = mem[i];
        exp_q.delete();
        run_model();
        @(posedge clk); #1 reset = 1'b1; waits = w;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_pc", 32'(dbg_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
    endtask

    task automatic finish_prog();
        bit done = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (halted) begin done = 1'b1; break; end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL halt_timeout: halted=%0b, expected 1", halted);
        end
        repeat (2) @(negedge clk);
        check("end_halted", 32'(halted), 32'd1);
        check("end_leds", 32'(leds), 32'(exp_leds));
        check("end_ovf", 32'(ovf), 32'(exp_ovf));
        check("end_pc", 32'(dbg_pc), 32'(exp_pc));
        check("end_req", 32'(mem_req), 32'd0);
        check("end_queue_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0]  = ins(0, 10, 0);
        mem[1]  = ins(2, 11, 0);
        mem[2]  = ins(1, 12, 0);
        mem[3]  = ins(7, 0, 0);
        mem[10] = 18'd5;
        mem[11] = 18'd7;
    endtask

    task automatic gen_random();
        int len, op, opnd, k;
        clear_mem();
        len = $urandom_range(4, 12);
        for (int i = 0; i < len - 1; i++) begin
            op = $urandom_range(0, 6);
            // Branch targets only point forward so every program terminates
            if (op >= 5) opnd = $urandom_range(i + 1, len - 1);
            else         opnd = 100 + $urandom_range(0, 7);
            mem[i] = ins(op, opnd, int'($urandom));
        end
        mem[len-1] = ins(7, int'($urandom_range(0, 8191)), int'($urandom));
        for (int a = 100; a < 108; a++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: mem[a] = 18'h1FFFF;
                1: mem[a] = 18'h20000;
                2: mem[a] = 18'h0;
                3: mem[a] = 18'h1;
                default: mem[a] = DW'($urandom);
            endcase
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem2[i] = '0;
        mem2[0]  = 12'h00A;   // LOAD 10
        mem2[1]  = 12'h20B;   // STORE 11
        mem2[2]  = 12'hE00;   // HALT
        mem2[10] = 12'hABC;

        // Basic program, zero-wait then three wait states
        load_basic();
        start_prog(0);
        finish_prog();
        check("basic_mem12", 32'(mem[12]), 32'd12);
        check("basic_leds", 32'(leds), 32'd12);
        load_basic();
        start_prog(3);
        finish_prog();
        check("wait_mem12", 32'(mem[12]), 32'd12);

        // Overflow is sticky through a later clean SUB
        clear_mem();
        mem[0] = ins(0, 100, 0);  mem[1] = ins(2, 101, 0);
        mem[2] = ins(1, 105, 0);  mem[3] = ins(0, 103, 0);
        mem[4] = ins(3, 102, 0);  mem[5] = ins(1, 104, 0);
        mem[6] = ins(7, 0, 0);
        mem[100] = 18'h1FFFF; mem[101] = 18'h1; mem[102] = 18'd5; mem[103] = 18'd10;
        start_prog(1);
        finish_prog();
        check("ovf_sum", 32'(mem[105]), 32'h20000);
        check("ovf_sub", 32'(mem[104]), 32'd5);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Branches: taken/not-taken JZ, JMP to the top address, PC wrap
        clear_mem();
        mem[0]  = ins(6, 30, 0);   mem[1]  = ins(7, 0, 0);
        mem[30] = ins(0, 50, 0);   mem[31] = ins(6, 40, 0);
        mem[32] = ins(0, 51, 0);   mem[33] = ins(6, 20, 0);
        mem[20] = ins(0, 50, 0);   mem[21] = ins(5, 13'h1FFF, 0);
        mem[13'h1FFF] = ins(2, 50, 0);
        mem[50] = 18'd3;
        start_prog(0);
        finish_prog();

        // Reset while a fetch waits for ack, then a stray ack with no request
        load_basic();
        start_prog(4);
        for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; inject_ack = 1'b1;
        @(negedge clk);
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_pc", 32'(dbg_pc), 32'd0);
        @(posedge clk); #1 inject_ack = 1'b0;
        @(negedge clk);
        check("stray_req", 32'(mem_req), 32'd1);
        check("stray_addr", 32'(mem_addr), 32'd0);
        check("stray_we", 32'(mem_we), 32'd0);
        check("stray_pc", 32'(dbg_pc), 32'd0);
        finish_prog();

        // Narrow instance ran its program after the first reset release
        check("narrow_leds", 32'(leds2), 32'hC);
        check("narrow_mem", 32'(mem2[11]), 32'hABC);
        check("narrow_halted", 32'(halted2), 32'd1);
        check("narrow_ovf", 32'(ovf2), 32'd0);

        // Random programs with random wait states
        for (int t = 0; t < 25; t++) begin
            gen_random();
            start_prog($urandom_range(0, 3));
            finish_prog();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
